// File: rtl/bnn_conv_feeder.sv
// Sequencer feeding the BNN conv engine: per job, walks all NSTAGE output channels,
// streaming LEN input words per stage and collecting one OL-bit result per stage.
// Latency: START at T puts word j on oDATA at T+1+j; a result appears the cycle after iCONV_END.
// Backpressure: oRES_VALID holds data/stage stable until iRES_READY, and the next stage waits for that accept.
//
// Ports:
//   iCLK, iRST_N              clock (rising edge), async active-low reset
//   iGO, iMODE, iBASE         job start; mode (0 conv2, 1 conv3) and base address sampled with iGO
//   oBUSY, oDONE, oERR        job in progress, end-of-job pulse, sticky engine-timeout flag
//   oRD_EN, oRD_ADDR          feature-buffer read port; iRD_DATA returns one cycle later
//   oSTART, oDATA             engine start code and input word stream
//   oSTATE, oCNT_STAGE        weight/threshold bank select and stage index, held for the whole stage
//   iCONV_DATA, iCONV_END     engine result and its one-cycle completion strobe
//   oRES_DATA, oRES_STAGE     captured result with its stage index
//   oRES_VALID, iRES_READY    downstream valid/ready handshake
module bnn_conv_feeder #(
    parameter int CH     = 48,
    parameter int OL     = 154,
    parameter int AW     = 8,
    parameter int NSTAGE = 48,
    parameter int LEN_C2 = 154,
    parameter int LEN_C3 = 88,
    parameter int TMO    = 1023
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic          iGO,
    input  logic          iMODE,
    input  logic [AW-1:0] iBASE,
    output logic          oBUSY,
    output logic          oDONE,
    output logic          oERR,
    output logic          oRD_EN,
    output logic [AW-1:0] oRD_ADDR,
    input  logic [CH-1:0] iRD_DATA,
    output logic [3:0]    oSTART,
    output logic [CH-1:0] oDATA,
    output logic [4:0]    oSTATE,
    output logic [5:0]    oCNT_STAGE,
    input  logic [OL-1:0] iCONV_DATA,
    input  logic          iCONV_END,
    output logic [OL-1:0] oRES_DATA,
    output logic [5:0]    oRES_STAGE,
    output logic          oRES_VALID,
    input  logic          iRES_READY
);

    // Word counter must reach LEN-1 of the longer mode.
    localparam int LMAX = (LEN_C2 > LEN_C3) ? LEN_C2 : LEN_C3;
    localparam int KW   = $clog2(LMAX);
    localparam int TW   = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_WAIT,
        S_EMIT,
        S_FIN
    } state_t;

    state_t          state;
    state_t          stateNxt;
    logic            modeR;
    logic [AW-1:0]   baseR;
    logic [KW-1:0]   wordCnt;
    logic [KW-1:0]   lastWord;
    logic [TW-1:0]   tmoCnt;
    logic [5:0]      stage;
    logic            rdVldD;
    logic            goAcc;
    logic            tmoHit;
    logic            lastStage;

    assign goAcc     = (state == S_IDLE) && iGO;
    assign lastWord  = modeR ? KW'(LEN_C3 - 1) : KW'(LEN_C2 - 1);
    assign tmoHit    = (tmoCnt == TW'(TMO - 1));
    assign lastStage = (stage == 6'(NSTAGE - 1));

    // State register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= S_IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    // Next-state logic
    always_comb begin
        stateNxt = state;
        unique case (state)
            S_IDLE:   if (iGO) stateNxt = S_START;
            S_START:  stateNxt = S_STREAM;
            S_STREAM: if (wordCnt == lastWord) stateNxt = S_WAIT;
            S_WAIT: begin
                // A completion on the final timeout cycle still counts as success.
                if (iCONV_END)   stateNxt = S_EMIT;
                else if (tmoHit) stateNxt = S_IDLE;
            end
            S_EMIT:   if (iRES_READY) stateNxt = lastStage ? S_FIN : S_START;
            S_FIN:    stateNxt = S_IDLE;
            default:  stateNxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        oBUSY      = (state != S_IDLE);
        oDONE      = (state == S_FIN);
        oRD_EN     = (state == S_START) || (state == S_STREAM);
        oRD_ADDR   = '0;
        oSTART     = 4'b0000;
        oSTATE     = 5'd0;
        oRES_VALID = (state == S_EMIT);
        oCNT_STAGE = stage;
        // Only words that were actually read reach the engine; gaps read as zero.
        oDATA      = rdVldD ? iRD_DATA : '0;
        if (oRD_EN) begin
            oRD_ADDR = baseR + AW'(wordCnt);
        end
        if (state == S_START) begin
            oSTART = modeR ? 4'b0100 : 4'b0010;
        end
        if ((state == S_START) || (state == S_STREAM) ||
            (state == S_WAIT)  || (state == S_EMIT)) begin
            oSTATE = modeR ? 5'd11 : 5'd7;
        end
    end

    // Job context, counters and result capture
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            modeR      <= 1'b0;
            baseR      <= '0;
            wordCnt    <= '0;
            tmoCnt     <= '0;
            stage      <= '0;
            rdVldD     <= 1'b0;
            oERR       <= 1'b0;
            oRES_DATA  <= '0;
            oRES_STAGE <= '0;
        end else begin
            rdVldD <= oRD_EN;

            if (goAcc) begin
                modeR <= iMODE;
                baseR <= iBASE;
                stage <= '0;
                oERR  <= 1'b0;
            end

            // Counter is 0 during START (address = base) and walks 1..LEN-1 in STREAM.
            if ((state == S_START) || (state == S_STREAM)) begin
                wordCnt <= wordCnt + 1'b1;
            end else begin
                wordCnt <= '0;
            end

            if (state == S_WAIT) begin
                tmoCnt <= tmoCnt + 1'b1;
            end else begin
                tmoCnt <= '0;
            end

            if ((state == S_WAIT) && !iCONV_END && tmoHit) begin
                oERR <= 1'b1;
            end

            if ((state == S_WAIT) && iCONV_END) begin
                oRES_DATA  <= iCONV_DATA;
                oRES_STAGE <= stage;
            end

            if ((state == S_EMIT) && iRES_READY && !lastStage) begin
                stage <= stage + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bnn_conv_feeder.sv
// Randomized bench for bnn_conv_feeder: buffer and engine models drive the DUT, a scoreboard
// queue carries each engine result to an independent result monitor.
module tb_bnn_conv_feeder;

    localparam int CH     = 48;
    localparam int OL     = 154;
    localparam int AW     = 8;
    localparam int NSTAGE = 48;
    localparam int LEN_C2 = 154;
    localparam int LEN_C3 = 88;
    localparam int TMO    = 1023;

    typedef struct {
        logic [OL-1:0] d;
        logic [5:0]    s;
    } res_t;

    logic          iCLK = 1'b0;
    logic          iRST_N = 1'b0;
    logic          iGO = 1'b0;
    logic          iMODE = 1'b0;
    logic [AW-1:0] iBASE = '0;
    logic          oBUSY, oDONE, oERR, oRD_EN;
    logic [AW-1:0] oRD_ADDR;
    logic [CH-1:0] iRD_DATA;
    logic [3:0]    oSTART;
    logic [CH-1:0] oDATA;
    logic [4:0]    oSTATE;
    logic [5:0]    oCNT_STAGE;
    logic [OL-1:0] iCONV_DATA;
    logic          iCONV_END;
    logic [OL-1:0] oRES_DATA;
    logic [5:0]    oRES_STAGE;
    logic          oRES_VALID;
    logic          iRES_READY;

    bnn_conv_feeder #(
        .CH(CH), .OL(OL), .AW(AW), .NSTAGE(NSTAGE),
        .LEN_C2(LEN_C2), .LEN_C3(LEN_C3), .TMO(TMO)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iGO(iGO), .iMODE(iMODE), .iBASE(iBASE),
        .oBUSY(oBUSY), .oDONE(oDONE), .oERR(oERR),
        .oRD_EN(oRD_EN), .oRD_ADDR(oRD_ADDR), .iRD_DATA(iRD_DATA),
        .oSTART(oSTART), .oDATA(oDATA), .oSTATE(oSTATE), .oCNT_STAGE(oCNT_STAGE),
        .iCONV_DATA(iCONV_DATA), .iCONV_END(iCONV_END),
        .oRES_DATA(oRES_DATA), .oRES_STAGE(oRES_STAGE),
        .oRES_VALID(oRES_VALID), .iRES_READY(iRES_READY)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdCnt = 0;
    int doneCnt = 0;
    int resCnt = 0;
    int lastAcceptCyc = 0;
    int stageStartCyc = 0;
    int jobId = 0;
    int engJob = 0;
    int modelStage = 0;
    bit jobMode = 1'b0;
    logic [AW-1:0] jobBase = '0;
    bit hang = 1'b0;
    bit stall5 = 1'b0;
    bit rdyRand = 1'b0;
    logic [CH-1:0] bufm [256];
    logic [CH-1:0] rdDataQ = '0;
    res_t expQ [$];

    always @(posedge iCLK) cyc <= cyc + 1;

    // Feature buffer: one-cycle read latency.
    always @(posedge iCLK) if (oRD_EN) rdDataQ <= bufm[oRD_ADDR];
    assign iRD_DATA = rdDataQ;

    always @(negedge iCLK) begin
        if (oRD_EN) rdCnt <= rdCnt + 1;
        if (oDONE)  doneCnt <= doneCnt + 1;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic randRes(output logic [OL-1:0] d);
        for (int i = 0; i < OL; i++) d[i] = 1'($urandom_range(0, 1));
    endtask

    // ---------------- Engine model ----------------
    task automatic runStage();
        int len;
        int dly;
        logic [3:0] code;
        logic [4:0] bank;
        bit spur;
        res_t r;
        if (engJob != jobId) begin
            engJob = jobId;
            modelStage = 0;
        end
        len  = jobMode ? LEN_C3 : LEN_C2;
        code = jobMode ? 4'b0100 : 4'b0010;
        bank = jobMode ? 5'd11 : 5'd7;
        stageStartCyc = cyc;
        chk("start_code", oSTART, code);
        chk("start_bank_stage", {oSTATE, oCNT_STAGE}, {bank, 6'(modelStage)});
        if (modelStage > 0) chk("start_after_accept", cyc, lastAcceptCyc + 1);
        spur = ($urandom_range(0, 3) == 0);
        for (int j = 0; j <= len; j++) begin
            if (j > 0) begin
                @(negedge iCLK);
                if (!iRST_N) begin
                    iCONV_END = 1'b0;
                    return;
                end
            end
            if (j < len) chk("rd_addr", {oRD_EN, oRD_ADDR}, {1'b1, 8'(int'(jobBase) + j)});
            else         chk("rd_stop", oRD_EN, 1'b0);
            if (j == 0) begin
                chk("data_idle", oDATA, '0);
            end else begin
                chk("data_word", oDATA, bufm[8'(int'(jobBase) + j - 1)]);
                chk("stage_hold", {oSTART, oSTATE, oCNT_STAGE}, {4'b0, bank, 6'(modelStage)});
            end
            // A completion strobe mid-stream must be ignored.
            if (spur && j == len / 2) begin
                iCONV_END = 1'b1;
                randRes(iCONV_DATA);
            end else begin
                iCONV_END = 1'b0;
            end
        end
        if (hang) return;
        dly = $urandom_range(0, 12);
        repeat (dly) begin
            @(negedge iCLK);
            if (!iRST_N) return;
        end
        r.s = 6'(modelStage);
        randRes(r.d);
        iCONV_END  = 1'b1;
        iCONV_DATA = r.d;
        expQ.push_back(r);
        modelStage++;
        @(negedge iCLK);
        iCONV_END = 1'b0;
        randRes(iCONV_DATA);
    endtask

    initial begin
        iCONV_END  = 1'b0;
        iCONV_DATA = '0;
        forever begin
            @(negedge iCLK);
            if (iRST_N && oSTART != 4'b0) runStage();
        end
    end

    // ---------------- Result monitor ----------------
    initial begin
        res_t e;
        bit holding;
        bit justAcc;
        bit rdy;
        int stallLeft;
        holding = 1'b0;
        justAcc = 1'b0;
        stallLeft = 0;
        e.d = '0;
        e.s = '0;
        iRES_READY = 1'b0;
        forever begin
            @(negedge iCLK);
            if (!iRST_N) begin
                holding = 1'b0;
                justAcc = 1'b0;
                stallLeft = 0;
                iRES_READY = 1'b0;
            end else if (justAcc) begin
                chk("valid_drop", oRES_VALID, 1'b0);
                justAcc = 1'b0;
                iRES_READY = 1'b0;
            end else if (oRES_VALID) begin
                if (!holding) begin
                    holding = 1'b1;
                    chk("queue_nonempty", expQ.size() > 0, 1'b1);
                    if (expQ.size() > 0) begin
                        e = expQ.pop_front();
                        chk("res_data", oRES_DATA, e.d);
                        chk("res_stage", oRES_STAGE, e.s);
                        if (stall5 && e.s == 6'd5) stallLeft = 20;
                    end
                end else begin
                    chk("res_hold", {oRES_VALID, oRES_STAGE, oRES_DATA, oSTART}, {1'b1, e.s, e.d, 4'b0});
                end
                if (stallLeft > 0) begin
                    rdy = 1'b0;
                    stallLeft--;
                end else begin
                    rdy = rdyRand ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
                iRES_READY = rdy;
                if (rdy) begin
                    holding = 1'b0;
                    justAcc = 1'b1;
                    lastAcceptCyc = cyc;
                    resCnt++;
                end
            end else begin
                iRES_READY = 1'b0;
            end
        end
    end

    // ---------------- Driver ----------------
    int rdBefore, resBefore, doneBefore;

    task automatic checkAllZero(input string tag);
        chk({tag, "_ctrl"}, {oBUSY, oDONE, oERR, oRD_EN, oRD_ADDR, oSTART, oSTATE,
                             oCNT_STAGE, oRES_VALID, oRES_STAGE}, '0);
        chk({tag, "_data"}, oDATA, '0);
        chk({tag, "_res"}, oRES_DATA, '0);
    endtask

    task automatic randBuf();
        for (int i = 0; i < 256; i++) bufm[i] = CH'({$urandom(), $urandom()});
    endtask

    task automatic startJob(input bit m, input logic [AW-1:0] b);
        jobId++;
        jobMode = m;
        jobBase = b;
        rdBefore = rdCnt;
        resBefore = resCnt;
        doneBefore = doneCnt;
        iGO = 1'b1;
        iMODE = m;
        iBASE = b;
        @(negedge iCLK);
        iGO = 1'b0;
        iMODE = ~m;
        iBASE = AW'($urandom);
        chk("go_busy_errclr", {oBUSY, oERR}, 2'b10);
    endtask

    task automatic waitDone(input int busyGoAt, input int len);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30000 && !seen; i++) begin
            @(negedge iCLK);
            if (busyGoAt > 0 && i == busyGoAt) begin
                iGO = 1'b1;
                iMODE = ~jobMode;
                iBASE = jobBase + 8'h40;
            end else begin
                iGO = 1'b0;
            end
            if (oDONE) begin
                seen = 1'b1;
                chk("done_timing", cyc, lastAcceptCyc + 1);
            end
        end
        iGO = 1'b0;
        chk("done_seen", seen, 1'b1);
        @(negedge iCLK);
        chk("idle_after_done", {oBUSY, oDONE}, 2'b00);
        repeat (2) @(negedge iCLK);
        chk("done_count", doneCnt - doneBefore, 1);
        chk("result_count", resCnt - resBefore, NSTAGE);
        chk("read_count", rdCnt - rdBefore, NSTAGE * len);
        chk("queue_empty", expQ.size(), 0);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 256; i++) bufm[i] = CH'(i);
        iRST_N = 1'b0;
        repeat (3) @(negedge iCLK);
        checkAllZero("reset");
        iRST_N = 1'b1;
        @(negedge iCLK);

        // conv2, base 0, identity buffer, downstream always ready
        startJob(1'b0, 8'h00);
        waitDone(0, LEN_C2);

        // conv3 from 0xF0 (address wrap), stall on stage 5, random ready, stray iGO while busy
        randBuf();
        stall5 = 1'b1;
        rdyRand = 1'b1;
        startJob(1'b1, 8'hF0);
        waitDone(500, LEN_C3);
        stall5 = 1'b0;

        // Engine never completes: timeout
        hang = 1'b1;
        startJob(1'b0, AW'($urandom));
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge iCLK);
            if (oERR) seen = 1'b1;
        end
        hang = 1'b0;
        chk("err_seen", seen, 1'b1);
        chk("err_timing", cyc, stageStartCyc + LEN_C2 + TMO);
        chk("err_idle", {oBUSY, oSTATE, oRD_EN, oRES_VALID}, '0);
        repeat (3) @(negedge iCLK);
        chk("err_sticky", oERR, 1'b1);
        chk("err_no_done", doneCnt - doneBefore, 0);
        chk("err_no_result", resCnt - resBefore, 0);

        // Fresh job clears oERR; abort it with reset during stage 3 streaming
        randBuf();
        startJob(1'b1, AW'($urandom));
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge iCLK);
            if (oCNT_STAGE == 6'd3 && oRD_EN && oSTART == 4'b0) seen = 1'b1;
        end
        chk("stage3_reached", seen, 1'b1);
        repeat (10) @(negedge iCLK);
        #2 iRST_N = 1'b0;
        #1 checkAllZero("abort");
        repeat (3) @(negedge iCLK);
        checkAllZero("abort_hold");
        chk("abort_no_done", doneCnt - doneBefore, 0);
        iRST_N = 1'b1;
        @(negedge iCLK);

        // Restart from stage 0 after the abort
        randBuf();
        startJob(1'b1, AW'($urandom));
        waitDone(0, LEN_C3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
